// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
//
// Purpose:
//   Receive side of a 4:1 time-division channel multiplexer. Words arrive one
//   per valid beat in fixed channel order 0,1,2,3, with slot 0 marked by sof.
//   The block aligns to sof, gathers slots 0..2 in shadow registers, and on the
//   slot-3 beat updates all four channel outputs together. A one-cycle
//   frame_valid pulse follows that update. A framing slip raises a one-cycle
//   sync_err pulse and bumps a saturating error counter.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          TDM data word (W bits)
//   din_valid    din carries a slot word this cycle (a "beat")
//   sof          start of frame, qualified by din_valid; word is slot 0
//   ch0..ch3     channel words from the last complete frame
//   frame_valid  one-cycle pulse when ch0..ch3 update
//   slot         slot index expected for the next accepted word
//   locked       high while aligned to the frame
//   sync_err     one-cycle pulse on a framing error
//   err_cnt      saturating count of sync_err events (ERRW bits)
// -----------------------------------------------------------------------------
module tdm_demux4 #(
  parameter int W    = 8,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    din,
  input  logic            din_valid,
  input  logic            sof,
  output logic [W-1:0]    ch0,
  output logic [W-1:0]    ch1,
  output logic [W-1:0]    ch2,
  output logic [W-1:0]    ch3,
  output logic            frame_valid,
  output logic [1:0]      slot,
  output logic            locked,
  output logic            sync_err,
  output logic [ERRW-1:0] err_cnt
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      slot_q, slot_d;
  logic [W-1:0]    shadow0_q, shadow0_d;
  logic [W-1:0]    shadow1_q, shadow1_d;
  logic [W-1:0]    shadow2_q, shadow2_d;
  logic [W-1:0]    ch0_q, ch0_d;
  logic [W-1:0]    ch1_q, ch1_d;
  logic [W-1:0]    ch2_q, ch2_d;
  logic [W-1:0]    ch3_q, ch3_d;
  logic            frame_valid_q, frame_valid_d;
  logic            sync_err_q, sync_err_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic            err_event;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      shadow0_q     <= '0;
      shadow1_q     <= '0;
      shadow2_q     <= '0;
      ch0_q         <= '0;
      ch1_q         <= '0;
      ch2_q         <= '0;
      ch3_q         <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow0_q     <= shadow0_d;
      shadow1_q     <= shadow1_d;
      shadow2_q     <= shadow2_d;
      ch0_q         <= ch0_d;
      ch1_q         <= ch1_d;
      ch2_q         <= ch2_d;
      ch3_q         <= ch3_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow0_d     = shadow0_q;
    shadow1_d     = shadow1_q;
    shadow2_d     = shadow2_q;
    ch0_d         = ch0_q;
    ch1_d         = ch1_q;
    ch2_d         = ch2_q;
    ch3_d         = ch3_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    err_cnt_d     = err_cnt_q;
    err_event     = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          // Non-sof words are dropped until the first slot-0 marker.
          if (sof) begin
            shadow0_d = din;
            slot_d    = 2'd1;
            state_d   = LOCKED;
          end
        end

        LOCKED: begin
          if (sof) begin
            // sof always restarts the frame; mid-frame it abandons the partial
            // frame without touching ch*, and stays locked.
            if (slot_q != 2'd0) begin
              err_event = 1'b1;
            end
            shadow0_d = din;
            slot_d    = 2'd1;
          end else begin
            unique case (slot_q)
              2'd0: begin
                // A frame boundary without sof means alignment was lost.
                err_event = 1'b1;
                state_d   = HUNT;
                slot_d    = 2'd0;
              end
              2'd1: begin
                shadow1_d = din;
                slot_d    = 2'd2;
              end
              2'd2: begin
                shadow2_d = din;
                slot_d    = 2'd3;
              end
              2'd3: begin
                // Slot 3 is taken straight from din so all four channels
                // update on the same edge.
                ch0_d         = shadow0_q;
                ch1_d         = shadow1_q;
                ch2_d         = shadow2_q;
                ch3_d         = din;
                frame_valid_d = 1'b1;
                slot_d        = 2'd0;
              end
              default: begin
                slot_d = 2'd0;
              end
            endcase
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = 2'd0;
        end
      endcase
    end

    if (err_event) begin
      sync_err_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERRW'(1);
      end
    end
  end

  assign ch0         = ch0_q;
  assign ch1         = ch1_q;
  assign ch2         = ch2_q;
  assign ch3         = ch3_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux4
//
// Directed bench for tdm_demux4. Two instances share the same stimulus: one at
// the default ERRW=8 and one at ERRW=2 so counter saturation can be seen
// without long error runs. Inputs change on the falling edge; outputs are
// sampled on the falling edge after the beat's rising edge.
// -----------------------------------------------------------------------------
module tb_tdm_demux4;

  // Clock, reset and shared stimulus
  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       sof;

  // Outputs of the default-width instance
  logic [7:0] ch0, ch1, ch2, ch3;
  logic       frame_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;
  logic [7:0] err_cnt;

  // Outputs of the narrow-counter instance
  logic [7:0] n_ch0, n_ch1, n_ch2, n_ch3;
  logic       n_frame_valid;
  logic [1:0] n_slot;
  logic       n_locked;
  logic       n_sync_err;
  logic [1:0] n_err_cnt;

  int checkCount = 0;
  int failCount  = 0;

  tdm_demux4 #(.W(8), .ERRW(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .frame_valid(frame_valid), .slot(slot), .locked(locked),
    .sync_err(sync_err), .err_cnt(err_cnt)
  );

  tdm_demux4 #(.W(8), .ERRW(2)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .ch0(n_ch0), .ch1(n_ch1), .ch2(n_ch2), .ch3(n_ch3),
    .frame_valid(n_frame_valid), .slot(n_slot), .locked(n_locked),
    .sync_err(n_sync_err), .err_cnt(n_err_cnt)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the sequence stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One beat: caller is on a falling edge; returns on the next falling edge,
  // where the registered effect of the beat is visible
  task automatic applyStimulus(input logic s, input logic [7:0] d);
    din_valid = 1'b1;
    sof       = s;
    din       = d;
    @(negedge clk);
    din_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // Idle cycles with no beat
  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sof raised without din_valid must be ignored
  task automatic straySof();
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  // Compare all four channel outputs against one expected frame
  task automatic checkFrame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    checkOutput({tag, ".ch0"}, 32'(ch0), 32'(e0));
    checkOutput({tag, ".ch1"}, 32'(ch1), 32'(e1));
    checkOutput({tag, ".ch2"}, 32'(ch2), 32'(e2));
    checkOutput({tag, ".ch3"}, 32'(ch3), 32'(e3));
  endtask

  // Main directed sequence
  initial begin
    rst_n     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    sof       = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    checkFrame("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("reset.frame_valid", 32'(frame_valid), 32'd0);
    checkOutput("reset.slot", 32'(slot), 32'd0);
    checkOutput("reset.locked", 32'(locked), 32'd0);
    checkOutput("reset.sync_err", 32'(sync_err), 32'd0);
    checkOutput("reset.err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Hunt discard: words before the first sof are dropped
    applyStimulus(1'b0, 8'hAA);
    applyStimulus(1'b0, 8'hBB);
    checkOutput("hunt.locked_before_sof", 32'(locked), 32'd0);
    checkOutput("hunt.slot_before_sof", 32'(slot), 32'd0);
    applyStimulus(1'b1, 8'h01);
    checkOutput("hunt.locked_on_sof", 32'(locked), 32'd1);
    checkOutput("hunt.slot_after_sof", 32'(slot), 32'd1);
    applyStimulus(1'b0, 8'h02);
    applyStimulus(1'b0, 8'h03);
    checkOutput("hunt.no_early_fv", 32'(frame_valid), 32'd0);
    applyStimulus(1'b0, 8'h04);
    checkOutput("hunt.frame_valid", 32'(frame_valid), 32'd1);
    checkFrame("hunt", 8'h01, 8'h02, 8'h03, 8'h04);

    // Basic back-to-back frame
    applyStimulus(1'b1, 8'h11);
    checkOutput("basic.fv_cleared", 32'(frame_valid), 32'd0);
    applyStimulus(1'b0, 8'h22);
    applyStimulus(1'b0, 8'h33);
    checkFrame("basic.hold", 8'h01, 8'h02, 8'h03, 8'h04);
    applyStimulus(1'b0, 8'h44);
    checkOutput("basic.frame_valid", 32'(frame_valid), 32'd1);
    checkFrame("basic", 8'h11, 8'h22, 8'h33, 8'h44);
    checkOutput("basic.locked", 32'(locked), 32'd1);
    checkOutput("basic.slot", 32'(slot), 32'd0);
    idleCycles(1);
    checkOutput("basic.fv_one_cycle", 32'(frame_valid), 32'd0);

    // Gapped beats with a stray sof in a gap
    applyStimulus(1'b1, 8'h05);
    straySof();
    idleCycles(1);
    checkOutput("gap.slot_after_stray", 32'(slot), 32'd1);
    checkOutput("gap.no_err_stray", 32'(sync_err), 32'd0);
    applyStimulus(1'b0, 8'h06);
    idleCycles(2);
    applyStimulus(1'b0, 8'h07);
    idleCycles(2);
    checkOutput("gap.no_fv_yet", 32'(frame_valid), 32'd0);
    applyStimulus(1'b0, 8'h08);
    checkOutput("gap.frame_valid", 32'(frame_valid), 32'd1);
    checkFrame("gap", 8'h05, 8'h06, 8'h07, 8'h08);
    checkOutput("gap.err_cnt", 32'(err_cnt), 32'd0);

    // Early sof abandons the partial frame
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b0, 8'h02);
    applyStimulus(1'b0, 8'h03);
    applyStimulus(1'b0, 8'h04);
    checkFrame("early.pre", 8'h01, 8'h02, 8'h03, 8'h04);
    applyStimulus(1'b1, 8'h09);
    applyStimulus(1'b0, 8'h0A);
    applyStimulus(1'b1, 8'h0B);
    checkOutput("early.sync_err", 32'(sync_err), 32'd1);
    checkOutput("early.err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("early.no_fv", 32'(frame_valid), 32'd0);
    checkOutput("early.locked", 32'(locked), 32'd1);
    checkOutput("early.slot", 32'(slot), 32'd1);
    applyStimulus(1'b0, 8'h0C);
    checkOutput("early.err_pulse_end", 32'(sync_err), 32'd0);
    applyStimulus(1'b0, 8'h0D);
    checkFrame("early.hold", 8'h01, 8'h02, 8'h03, 8'h04);
    applyStimulus(1'b0, 8'h0E);
    checkOutput("early.frame_valid", 32'(frame_valid), 32'd1);
    checkFrame("early", 8'h0B, 8'h0C, 8'h0D, 8'h0E);

    // Missing sof at a frame boundary drops lock
    applyStimulus(1'b0, 8'h55);
    checkOutput("miss.sync_err", 32'(sync_err), 32'd1);
    checkOutput("miss.locked", 32'(locked), 32'd0);
    checkOutput("miss.slot", 32'(slot), 32'd0);
    checkOutput("miss.err_cnt", 32'(err_cnt), 32'd2);
    checkFrame("miss.hold", 8'h0B, 8'h0C, 8'h0D, 8'h0E);
    applyStimulus(1'b1, 8'h61);
    checkOutput("miss.relock", 32'(locked), 32'd1);
    applyStimulus(1'b0, 8'h62);
    applyStimulus(1'b0, 8'h63);
    applyStimulus(1'b0, 8'h64);
    checkOutput("miss.frame_valid", 32'(frame_valid), 32'd1);
    checkFrame("miss.recover", 8'h61, 8'h62, 8'h63, 8'h64);

    // Saturation: five consecutive early-sof errors
    applyStimulus(1'b1, 8'h70);
    checkOutput("sat.no_err_start", 32'(sync_err), 32'd0);
    applyStimulus(1'b1, 8'h71);
    checkOutput("sat.narrow_first", 32'(n_err_cnt), 32'd3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h72);
    end
    checkOutput("sat.narrow_err_cnt", 32'(n_err_cnt), 32'd3);
    checkOutput("sat.wide_err_cnt", 32'(err_cnt), 32'd7);
    checkOutput("sat.narrow_sync_err", 32'(n_sync_err), 32'd1);

    // Reset mid-frame clears immediately
    applyStimulus(1'b1, 8'h81);
    applyStimulus(1'b0, 8'h82);
    #2;
    rst_n = 1'b0;
    #1;
    checkFrame("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("midrst.locked", 32'(locked), 32'd0);
    checkOutput("midrst.slot", 32'(slot), 32'd0);
    checkOutput("midrst.err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("midrst.narrow_err_cnt", 32'(n_err_cnt), 32'd0);
    checkOutput("midrst.sync_err", 32'(sync_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // After reset, a frame without sof is ignored
    applyStimulus(1'b0, 8'h91);
    applyStimulus(1'b0, 8'h92);
    applyStimulus(1'b0, 8'h93);
    applyStimulus(1'b0, 8'h94);
    checkOutput("postrst.no_fv", 32'(frame_valid), 32'd0);
    checkOutput("postrst.locked", 32'(locked), 32'd0);
    checkOutput("postrst.err_cnt", 32'(err_cnt), 32'd0);
    checkFrame("postrst.hold", 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 8'hA1);
    applyStimulus(1'b0, 8'hA2);
    applyStimulus(1'b0, 8'hA3);
    applyStimulus(1'b0, 8'hA4);
    checkOutput("postrst.frame_valid", 32'(frame_valid), 32'd1);
    checkFrame("postrst", 8'hA1, 8'hA2, 8'hA3, 8'hA4);

    idleCycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
